rd_empty_flag_gen: RTL

Read-domain status block for the asynchronous FIFO. It brings the Gray-coded write pointer into the rd_clk domain and converts it back to binary. It compares that pointer against the binary read pointer from the read-control counter and drives f_empty, which gates that counter's enable. It also exports a registered Gray copy of the read pointer for the write-domain full-flag logic, plus read-side occupancy and almost-empty.

---
 rtl/rd_empty_flag_gen_pkg.sv | 15 +
 rtl/rd_empty_flag_gen_gray_ptr_sync.sv | 53 +++++
 rtl/rd_empty_flag_gen.sv | 73 +++++++
 3 files changed

// File: rtl/rd_empty_flag_gen_pkg.sv
// Shared constants for the read-domain empty-flag block.
// RD_SYNC3_EN: when defined, the write-pointer synchronizer uses three flops instead of two.
package rd_empty_flag_gen_pkg;

  localparam int unsigned ALength  = 4;
  localparam int unsigned Depth    = 1 << ALength;
  localparam int unsigned AeThresh = 2;

`ifdef RD_SYNC3_EN
  localparam int unsigned SyncStages = 3;
`else
  localparam int unsigned SyncStages = 2;
`endif

endpackage

// File: rtl/rd_empty_flag_gen_gray_ptr_sync.sv
// Gray pointer synchronizer: Stages-deep flop chain followed by a registered gray-to-binary
// conversion. Also usable by the write-domain full-flag generator.
module rd_empty_flag_gen_gray_ptr_sync
  import rd_empty_flag_gen_pkg::*;
#(
  parameter int unsigned Width  = ALength + 1,
  parameter int unsigned Stages = SyncStages
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] gray_i,
  output logic [Width-1:0] bin_o
);

  logic [Width-1:0] sync_q [Stages];
  logic [Width-1:0] bin_d;
  logic [Width-1:0] bin_q;

  // Plain flop chain; no logic between stages so only one bit can be in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Gray to binary: MSB copies through, each lower bit folds in the bit above.
  always_comb begin
    bin_d = '0;
    bin_d[Width-1] = sync_q[Stages-1][Width-1];
    for (int i = int'(Width) - 2; i >= 0; i--) begin
      bin_d[i] = bin_d[i+1] ^ sync_q[Stages-1][i];
    end
  end

  // Register the converted value so downstream compare logic sees a clean flop output.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
    end else begin
      bin_q <= bin_d;
    end
  end

  assign bin_o = bin_q;

endmodule

// File: rtl/rd_empty_flag_gen.sv
// Read-domain status for the async FIFO: synchronizes the Gray write pointer, derives
// f_empty / occupancy / almost_empty, and exports a registered Gray read pointer.
// RD_SYNC3_EN: when defined, adds a third synchronizer flop (write-pointer latency 4 edges).
module rd_empty_flag_gen
  import rd_empty_flag_gen_pkg::*;
#(
  parameter int unsigned A_LENGTH  = ALength,
  parameter int unsigned AE_THRESH = AeThresh
) (
  input  logic              rd_clk,
  input  logic              reset_n,
  input  logic [A_LENGTH:0] rd_ptr,
  input  logic [A_LENGTH:0] wr_ptr_gray,
  output logic              f_empty,
  output logic              almost_empty,
  output logic [A_LENGTH:0] rd_count,
  output logic [A_LENGTH:0] rd_ptr_gray,
  output logic [A_LENGTH:0] wr_ptr_sync
);

  function automatic logic [A_LENGTH:0] bin2gray(input logic [A_LENGTH:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [A_LENGTH:0] rd_ptr_gray_d;
  logic [A_LENGTH:0] rd_ptr_gray_q;

  rd_empty_flag_gen_gray_ptr_sync #(
    .Width  (A_LENGTH + 1),
    .Stages (SyncStages)
  ) u_wr_ptr_sync (
    .clk_i  (rd_clk),
    .rst_ni (reset_n),
    .gray_i (wr_ptr_gray),
    .bin_o  (wr_ptr_sync)
  );

  // Gray-encode the read pointer for the write domain.
  always_comb begin
    rd_ptr_gray_d = bin2gray(rd_ptr);
  end

  // Register the Gray copy so the crossing sees only single-bit, glitch-free changes.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_gray_q <= '0;
    end else begin
      rd_ptr_gray_q <= rd_ptr_gray_d;
    end
  end

  assign rd_ptr_gray = rd_ptr_gray_q;

  // Flags are combinational so read control sees them in the same cycle rd_ptr moves; a
  // stale wr_ptr_sync only ever under-reports occupancy.
  always_comb begin
    rd_count     = wr_ptr_sync - rd_ptr;
    f_empty      = (rd_ptr == wr_ptr_sync);
    almost_empty = (32'(rd_count) <= AE_THRESH);
  end

`ifndef SYNTHESIS
  logic [A_LENGTH:0] wr_gray_prev;

  // The write side must move its Gray pointer one bit at a time.
  always @(wr_ptr_gray) begin
    assert ($isunknown(wr_gray_prev) || ($countones(wr_ptr_gray ^ wr_gray_prev) <= 1))
      else $error("wr_ptr_gray changed by more than one bit");
    wr_gray_prev = wr_ptr_gray;
  end
`endif

endmodule
